// File: rtl/decode_stage_rf.sv
// decode_stage_rf: Y86-64 decode stage with register file, source/destination
// selection, forwarding network and the decode->execute pipeline register.
// Optional feature macro: DECODE_FWD_EN
//   defined   -> five-source forwarding, load_use_o flags load/use only
//   undefined -> regfile-only operands, load_use_o flags any pending writer
module decode_stage_rf #(
    parameter int XLEN  = 64,
    parameter int NREG  = 15,
    parameter int RID_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             E_stall_i,
    input  logic             E_bubble_i,
    input  logic [2:0]       D_stat_i,
    input  logic [XLEN-1:0]  D_pc_i,
    input  logic [3:0]       D_icode_i,
    input  logic [3:0]       D_ifun_i,
    input  logic [RID_W-1:0] D_rA_i,
    input  logic [RID_W-1:0] D_rB_i,
    input  logic [XLEN-1:0]  D_valC_i,
    input  logic [XLEN-1:0]  D_valP_i,
    input  logic [RID_W-1:0] e_dstE_i,
    input  logic [XLEN-1:0]  e_valE_i,
    input  logic [RID_W-1:0] M_dstM_i,
    input  logic [XLEN-1:0]  m_valM_i,
    input  logic [RID_W-1:0] M_dstE_i,
    input  logic [XLEN-1:0]  M_valE_i,
    input  logic [RID_W-1:0] W_dstM_i,
    input  logic [RID_W-1:0] W_dstE_i,
    input  logic [XLEN-1:0]  W_valM_i,
    input  logic [XLEN-1:0]  W_valE_i,
    output logic [RID_W-1:0] d_srcA_o,
    output logic [RID_W-1:0] d_srcB_o,
    output logic             load_use_o,
    output logic [2:0]       E_stat_o,
    output logic [XLEN-1:0]  E_pc_o,
    output logic [3:0]       E_icode_o,
    output logic [3:0]       E_ifun_o,
    output logic [XLEN-1:0]  E_valC_o,
    output logic [XLEN-1:0]  E_valA_o,
    output logic [XLEN-1:0]  E_valB_o,
    output logic [RID_W-1:0] E_dstE_o,
    output logic [RID_W-1:0] E_dstM_o,
    output logic [RID_W-1:0] E_srcA_o,
    output logic [RID_W-1:0] E_srcB_o
);

    localparam logic [RID_W-1:0] RNONE    = '1;
    localparam logic [RID_W-1:0] RSP      = RID_W'(4);
    localparam logic [RID_W:0]   NREG_EXT = (RID_W + 1)'(NREG);

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [2:0] SAOK     = 3'd1;

    // True for an ID that names a physical register (not RNONE, below NREG).
    function automatic logic id_ok(input logic [RID_W-1:0] id);
        return (id != RNONE) && ({1'b0, id} < NREG_EXT);
    endfunction

    logic [XLEN-1:0]  rf_q [NREG];
    logic [RID_W-1:0] srcA, srcB, dstE, dstM;
    logic [XLEN-1:0]  rf_a, rf_b, valA_d, valB_d;

    logic [2:0]       E_stat_q;
    logic [XLEN-1:0]  E_pc_q, E_valC_q, E_valA_q, E_valB_q;
    logic [3:0]       E_icode_q, E_ifun_q;
    logic [RID_W-1:0] E_dstE_q, E_dstM_q, E_srcA_q, E_srcB_q;

    // Source and destination register selection from icode.
    always_comb begin
        srcA = RNONE;
        srcB = RNONE;
        dstE = RNONE;
        dstM = RNONE;
        case (D_icode_i)
            I_RRMOVQ: begin srcA = D_rA_i; dstE = D_rB_i; end
            I_IRMOVQ: dstE = D_rB_i;
            I_RMMOVQ: begin srcA = D_rA_i; srcB = D_rB_i; end
            I_MRMOVQ: begin srcB = D_rB_i; dstM = D_rA_i; end
            I_OPQ:    begin srcA = D_rA_i; srcB = D_rB_i; dstE = D_rB_i; end
            I_PUSHQ:  begin srcA = D_rA_i; srcB = RSP; dstE = RSP; end
            I_POPQ:   begin srcA = RSP; srcB = RSP; dstE = RSP; dstM = D_rA_i; end
            I_CALL:   begin srcB = RSP; dstE = RSP; end
            I_RET:    begin srcA = RSP; srcB = RSP; dstE = RSP; end
            default:  ;
        endcase
    end

    // Register file writes; the M port is applied last so it wins on a tie.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else begin
            if (id_ok(W_dstE_i)) rf_q[W_dstE_i] <= W_valE_i;
            if (id_ok(W_dstM_i)) rf_q[W_dstM_i] <= W_valM_i;
        end
    end

    assign rf_a = id_ok(srcA) ? rf_q[srcA] : '0;
    assign rf_b = id_ok(srcB) ? rf_q[srcB] : '0;

`ifdef DECODE_FWD_EN
    // Youngest in-flight producer wins; RNONE never matches.
    function automatic logic [XLEN-1:0] fwd(input logic [RID_W-1:0] src,
                                            input logic [XLEN-1:0]  rfv);
        if (src == RNONE)    return rfv;
        if (src == e_dstE_i) return e_valE_i;
        if (src == M_dstM_i) return m_valM_i;
        if (src == M_dstE_i) return M_valE_i;
        if (src == W_dstM_i) return W_valM_i;
        if (src == W_dstE_i) return W_valE_i;
        return rfv;
    endfunction

    // Operand selection with forwarding; CALL/JXX carry valP in valA.
    always_comb begin
        valA_d = fwd(srcA, rf_a);
        valB_d = fwd(srcB, rf_b);
        if (D_icode_i == I_CALL || D_icode_i == I_JXX) valA_d = D_valP_i;
    end

    // Load/use: a load in E whose destination a decode source needs.
    always_comb begin
        load_use_o = ((E_icode_q == I_MRMOVQ) || (E_icode_q == I_POPQ)) &&
                     (E_dstM_q != RNONE) &&
                     ((E_dstM_q == srcA) || (E_dstM_q == srcB));
    end
`else
    // Without forwarding the execute-stage result is never consumed here.
    logic unused_fwd;
    assign unused_fwd = ^{e_dstE_i, e_valE_i, m_valM_i, M_valE_i};

    function automatic logic pending(input logic [RID_W-1:0] src);
        return (src != RNONE) &&
               ((src == E_dstE_q) || (src == E_dstM_q) || (src == M_dstE_i) ||
                (src == M_dstM_i) || (src == W_dstE_i) || (src == W_dstM_i));
    endfunction

    // Operands straight from the register file; CALL/JXX carry valP in valA.
    always_comb begin
        valA_d = rf_a;
        valB_d = rf_b;
        if (D_icode_i == I_CALL || D_icode_i == I_JXX) valA_d = D_valP_i;
    end

    // Generic data hazard: any source still owed a write by a later stage.
    always_comb begin
        load_use_o = pending(srcA) || pending(srcB);
    end
`endif

    // Decode->execute register: reset and bubble insert a NOP, stall holds.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i || E_bubble_i) begin
            if (!rst_n_i || E_bubble_i) begin
                E_stat_q  <= SAOK;
                E_pc_q    <= '0;
                E_icode_q <= I_NOP;
                E_ifun_q  <= '0;
                E_valC_q  <= '0;
                E_valA_q  <= '0;
                E_valB_q  <= '0;
                E_dstE_q  <= RNONE;
                E_dstM_q  <= RNONE;
                E_srcA_q  <= RNONE;
                E_srcB_q  <= RNONE;
            end
        end else if (!E_stall_i) begin
            E_stat_q  <= D_stat_i;
            E_pc_q    <= D_pc_i;
            E_icode_q <= D_icode_i;
            E_ifun_q  <= D_ifun_i;
            E_valC_q  <= D_valC_i;
            E_valA_q  <= valA_d;
            E_valB_q  <= valB_d;
            E_dstE_q  <= dstE;
            E_dstM_q  <= dstM;
            E_srcA_q  <= srcA;
            E_srcB_q  <= srcB;
        end
    end

    assign d_srcA_o  = srcA;
    assign d_srcB_o  = srcB;
    assign E_stat_o  = E_stat_q;
    assign E_pc_o    = E_pc_q;
    assign E_icode_o = E_icode_q;
    assign E_ifun_o  = E_ifun_q;
    assign E_valC_o  = E_valC_q;
    assign E_valA_o  = E_valA_q;
    assign E_valB_o  = E_valB_q;
    assign E_dstE_o  = E_dstE_q;
    assign E_dstM_o  = E_dstM_q;
    assign E_srcA_o  = E_srcA_q;
    assign E_srcB_o  = E_srcB_q;

endmodule

// File: tb/tb_decode_stage_rf.sv
// Directed bench for decode_stage_rf: decode table, forwarding/hazard
// sequences, stall hold and asynchronous reset mid-stall.
module tb_decode_stage_rf;

`ifdef DECODE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        E_stall_i, E_bubble_i;
    logic [2:0]  D_stat_i;
    logic [63:0] D_pc_i, D_valC_i, D_valP_i;
    logic [3:0]  D_icode_i, D_ifun_i, D_rA_i, D_rB_i;
    logic [3:0]  e_dstE_i, M_dstM_i, M_dstE_i, W_dstM_i, W_dstE_i;
    logic [63:0] e_valE_i, m_valM_i, M_valE_i, W_valM_i, W_valE_i;
    logic [3:0]  d_srcA_o, d_srcB_o;
    logic        load_use_o;
    logic [2:0]  E_stat_o;
    logic [63:0] E_pc_o, E_valC_o, E_valA_o, E_valB_o;
    logic [3:0]  E_icode_o, E_ifun_o, E_dstE_o, E_dstM_o, E_srcA_o, E_srcB_o;

    int total = 0;
    int bad   = 0;

    decode_stage_rf dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .E_stall_i(E_stall_i), .E_bubble_i(E_bubble_i),
        .D_stat_i(D_stat_i), .D_pc_i(D_pc_i), .D_icode_i(D_icode_i),
        .D_ifun_i(D_ifun_i), .D_rA_i(D_rA_i), .D_rB_i(D_rB_i),
        .D_valC_i(D_valC_i), .D_valP_i(D_valP_i),
        .e_dstE_i(e_dstE_i), .e_valE_i(e_valE_i),
        .M_dstM_i(M_dstM_i), .m_valM_i(m_valM_i),
        .M_dstE_i(M_dstE_i), .M_valE_i(M_valE_i),
        .W_dstM_i(W_dstM_i), .W_dstE_i(W_dstE_i),
        .W_valM_i(W_valM_i), .W_valE_i(W_valE_i),
        .d_srcA_o(d_srcA_o), .d_srcB_o(d_srcB_o), .load_use_o(load_use_o),
        .E_stat_o(E_stat_o), .E_pc_o(E_pc_o), .E_icode_o(E_icode_o),
        .E_ifun_o(E_ifun_o), .E_valC_o(E_valC_o), .E_valA_o(E_valA_o),
        .E_valB_o(E_valB_o), .E_dstE_o(E_dstE_o), .E_dstM_o(E_dstM_o),
        .E_srcA_o(E_srcA_o), .E_srcB_o(E_srcB_o)
    );

    // Clock.
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp, vala, valb;
        logic [3:0]  dste, dstm, srca, srcb;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        E_stall_i = 0; E_bubble_i = 0;
        D_stat_i = 3'd1; D_pc_i = 0; D_icode_i = 4'h1; D_ifun_i = 0;
        D_rA_i = 4'hF; D_rB_i = 4'hF; D_valC_i = 0; D_valP_i = 0;
        e_dstE_i = 4'hF; M_dstM_i = 4'hF; M_dstE_i = 4'hF;
        W_dstM_i = 4'hF; W_dstE_i = 4'hF;
        e_valE_i = 0; m_valM_i = 0; M_valE_i = 0; W_valM_i = 0; W_valE_i = 0;
    endtask

    task automatic set_d(input logic [3:0] icode, input logic [3:0] ra,
                         input logic [3:0] rb, input logic [63:0] valc);
        D_icode_i = icode; D_rA_i = ra; D_rB_i = rb; D_valC_i = valc;
    endtask

    task automatic check_bubble(input string tag);
        check({tag, "_icode"}, 64'(E_icode_o), 64'h1);
        check({tag, "_stat"},  64'(E_stat_o),  64'h1);
        check({tag, "_dstE"},  64'(E_dstE_o),  64'hF);
        check({tag, "_srcA"},  64'(E_srcA_o),  64'hF);
        check({tag, "_valA"},  E_valA_o,       64'h0);
        check({tag, "_pc"},    E_pc_o,         64'h0);
    endtask

    initial begin
        // icode ifun rA rB valC valP | valA valB dstE dstM srcA srcB
        vecs[0]  = '{4'h6, 4'h0, 4'h3, 4'h1, 64'h0,  64'h0,   64'h11,  64'h22, 4'h1, 4'hF, 4'h3, 4'h1};
        vecs[1]  = '{4'h2, 4'h0, 4'h1, 4'h5, 64'h0,  64'h0,   64'h22,  64'h0,  4'h5, 4'hF, 4'h1, 4'hF};
        vecs[2]  = '{4'h3, 4'h0, 4'hF, 4'h2, 64'h77, 64'h0,   64'h0,   64'h0,  4'h2, 4'hF, 4'hF, 4'hF};
        vecs[3]  = '{4'h4, 4'h0, 4'h3, 4'h1, 64'h8,  64'h0,   64'h11,  64'h22, 4'hF, 4'hF, 4'h3, 4'h1};
        vecs[4]  = '{4'h5, 4'h0, 4'h6, 4'h3, 64'h10, 64'h0,   64'h0,   64'h11, 4'hF, 4'h6, 4'hF, 4'h3};
        vecs[5]  = '{4'hA, 4'h0, 4'h1, 4'hF, 64'h0,  64'h0,   64'h22,  64'h0,  4'h4, 4'hF, 4'h1, 4'h4};
        vecs[6]  = '{4'hB, 4'h0, 4'h3, 4'hF, 64'h0,  64'h0,   64'h0,   64'h0,  4'h4, 4'h3, 4'h4, 4'h4};
        vecs[7]  = '{4'h8, 4'h0, 4'hF, 4'hF, 64'h50, 64'h109, 64'h109, 64'h0,  4'h4, 4'hF, 4'hF, 4'h4};
        vecs[8]  = '{4'h9, 4'h0, 4'hF, 4'hF, 64'h0,  64'h0,   64'h0,   64'h0,  4'h4, 4'hF, 4'h4, 4'h4};
        vecs[9]  = '{4'h7, 4'h3, 4'hF, 4'hF, 64'h60, 64'h200, 64'h200, 64'h0,  4'hF, 4'hF, 4'hF, 4'hF};
        vecs[10] = '{4'h1, 4'h0, 4'h3, 4'h1, 64'h0,  64'h0,   64'h0,   64'h0,  4'hF, 4'hF, 4'hF, 4'hF};
        vecs[11] = '{4'h6, 4'h2, 4'hF, 4'h3, 64'h0,  64'h0,   64'h0,   64'h11, 4'h3, 4'hF, 4'hF, 4'h3};

        // Reset with all inputs unknown.
        rst_n_i = 1'b1;
        E_stall_i = 'x; E_bubble_i = 'x; D_stat_i = 'x; D_pc_i = 'x;
        D_icode_i = 'x; D_ifun_i = 'x; D_rA_i = 'x; D_rB_i = 'x;
        D_valC_i = 'x; D_valP_i = 'x; e_dstE_i = 'x; e_valE_i = 'x;
        M_dstM_i = 'x; m_valM_i = 'x; M_dstE_i = 'x; M_valE_i = 'x;
        W_dstM_i = 'x; W_dstE_i = 'x; W_valM_i = 'x; W_valE_i = 'x;
        #1 rst_n_i = 1'b0;
        #2;
        check_bubble("rst_async");
        tick(); tick();
        check_bubble("rst_held");
        idle();
        rst_n_i = 1'b1;
        #1;
        check_bubble("rst_release");

        // Every register reads zero after reset.
        set_d(4'h6, 4'h0, 4'hE, 64'h0);
        tick();
        check("rst_rf_valA", E_valA_o, 64'h0);
        check("rst_rf_valB", E_valB_o, 64'h0);
        check("rst_rf_icode", 64'(E_icode_o), 64'h6);

        // Writeback: %rbx (3) = 0x11 via E port, %rcx (1) = 0x22 via M port.
        idle();
        W_dstE_i = 4'h3; W_valE_i = 64'h11;
        W_dstM_i = 4'h1; W_valM_i = 64'h22;
        tick();
        W_dstE_i = 4'hF; W_dstM_i = 4'hF;

        // Decode table.
        for (int i = 0; i < 12; i++) begin
            D_icode_i = vecs[i].icode; D_ifun_i = vecs[i].ifun;
            D_rA_i = vecs[i].ra; D_rB_i = vecs[i].rb;
            D_valC_i = vecs[i].valc; D_valP_i = vecs[i].valp;
            D_pc_i = 64'(i * 16);
            #1;
            check($sformatf("v%0d_d_srcA", i), 64'(d_srcA_o), 64'(vecs[i].srca));
            check($sformatf("v%0d_d_srcB", i), 64'(d_srcB_o), 64'(vecs[i].srcb));
            tick();
            check($sformatf("v%0d_valA", i),  E_valA_o, vecs[i].vala);
            check($sformatf("v%0d_valB", i),  E_valB_o, vecs[i].valb);
            check($sformatf("v%0d_dstE", i),  64'(E_dstE_o), 64'(vecs[i].dste));
            check($sformatf("v%0d_dstM", i),  64'(E_dstM_o), 64'(vecs[i].dstm));
            check($sformatf("v%0d_srcA", i),  64'(E_srcA_o), 64'(vecs[i].srca));
            check($sformatf("v%0d_srcB", i),  64'(E_srcB_o), 64'(vecs[i].srcb));
            check($sformatf("v%0d_icode", i), 64'(E_icode_o), 64'(vecs[i].icode));
            check($sformatf("v%0d_ifun", i),  64'(E_ifun_o), 64'(vecs[i].ifun));
            check($sformatf("v%0d_valC", i),  E_valC_o, vecs[i].valc);
            check($sformatf("v%0d_pc", i),    E_pc_o, 64'(i * 16));
        end

        // Forwarding priority on %rdx (2), which still holds 0.
        idle();
        set_d(4'h2, 4'h2, 4'h0, 64'h0);
        e_dstE_i = 4'h2; e_valE_i = 64'hAA;
        M_dstE_i = 4'h2; M_valE_i = 64'hBB;
        W_dstE_i = 4'h2; W_valE_i = 64'hCC;
        #1;
        check("fwd_hazard", 64'(load_use_o), FWD ? 64'h0 : 64'h1);
        tick();
        check("fwd_e", E_valA_o, FWD ? 64'hAA : 64'h0);
        e_dstE_i = 4'hF;
        tick();
        check("fwd_M_E", E_valA_o, FWD ? 64'hBB : 64'hCC);
        M_dstM_i = 4'h2; m_valM_i = 64'h55;
        tick();
        check("fwd_M_M", E_valA_o, FWD ? 64'h55 : 64'hCC);

        // An RNONE destination must never be forwarded.
        idle();
        set_d(4'h3, 4'hF, 4'h0, 64'h5);
        e_dstE_i = 4'hF; e_valE_i = 64'hDEAD;
        M_dstM_i = 4'hF; m_valM_i = 64'hBEEF;
        W_dstE_i = 4'hF; W_valE_i = 64'hCAFE;
        tick();
        check("rnone_valA", E_valA_o, 64'h0);
        check("rnone_valB", E_valB_o, 64'h0);

        // W_dstM beats W_dstE in both forwarding and the regfile write.
        idle();
        set_d(4'h2, 4'h2, 4'h0, 64'h0);
        W_dstM_i = 4'h2; W_valM_i = 64'h66;
        W_dstE_i = 4'h2; W_valE_i = 64'h77;
        tick();
        check("fwd_W_M", E_valA_o, FWD ? 64'h66 : 64'hCC);
        W_dstM_i = 4'hF; W_dstE_i = 4'hF;
        tick();
        check("rf_tie_M", E_valA_o, 64'h66);

        // Load/use: MRMOVQ into %rbx followed by a reader of %rbx.
        idle();
        set_d(4'h5, 4'h3, 4'h1, 64'h0);
        tick();
        set_d(4'h6, 4'h3, 4'h1, 64'h0);
        #1;
        check("lu_hit", 64'(load_use_o), 64'h1);
        set_d(4'h6, 4'h5, 4'h6, 64'h0);
        #1;
        check("lu_miss", 64'(load_use_o), 64'h0);
        set_d(4'h6, 4'h3, 4'h1, 64'h0);
        E_bubble_i = 1; E_stall_i = 1;
        tick();
        E_bubble_i = 0; E_stall_i = 0;
        check("bub_icode", 64'(E_icode_o), 64'h1);
        check("bub_dstM",  64'(E_dstM_o),  64'hF);
        check("bub_valA",  E_valA_o,       64'h0);
        check("bub_stat",  64'(E_stat_o),  64'h1);

        // IRMOVQ into %rbx then ADDQ reading it: hazard only without forwarding.
        set_d(4'h3, 4'hF, 4'h3, 64'h9);
        tick();
        set_d(4'h6, 4'h0, 4'h3, 64'h0);
        #1;
        check("irmov_addq", 64'(load_use_o), FWD ? 64'h0 : 64'h1);

        // popq %rsp rule on %rsp.
        idle();
        W_dstE_i = 4'h4; W_valE_i = 64'h10;
        W_dstM_i = 4'h4; W_valM_i = 64'h20;
        tick();
        W_dstE_i = 4'hF; W_dstM_i = 4'hF;
        set_d(4'h2, 4'h4, 4'h0, 64'h0);
        tick();
        check("rsp_tie", E_valA_o, 64'h20);

        // Stall holds E while D changes; reset mid-stall bubbles at once.
        idle();
        set_d(4'h6, 4'h3, 4'h1, 64'h0);
        D_pc_i = 64'h300;
        tick();
        check("pre_stall_valA", E_valA_o, 64'h11);
        E_stall_i = 1;
        for (int k = 0; k < 2; k++) begin
            set_d(4'h3, 4'hF, 4'h5, 64'h1234 + 64'(k));
            D_pc_i = 64'h400 + 64'(k);
            tick();
            check($sformatf("stall%0d_icode", k), 64'(E_icode_o), 64'h6);
            check($sformatf("stall%0d_valA", k),  E_valA_o,       64'h11);
            check($sformatf("stall%0d_dstE", k),  64'(E_dstE_o),  64'h1);
            check($sformatf("stall%0d_pc", k),    E_pc_o,         64'h300);
        end
        #2 rst_n_i = 1'b0;
        #1;
        check_bubble("rst_mid_stall");
        tick();
        rst_n_i = 1'b1;
        E_stall_i = 0;
        set_d(4'h6, 4'h3, 4'h1, 64'h0);
        tick();
        check("post_rst_valA", E_valA_o, 64'h0);
        check("post_rst_dstE", 64'(E_dstE_o), 64'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_stage_rf.md
# decode_stage_rf

Parametrised Y86-64 decode stage. It merges the register file, source/destination selection, the five-source forwarding network and the decode→execute pipeline register into one block. It sits between `fetch_D_pipe_reg` and the execute stage, and replaces the separate `decode` + `decode_E_pipe_reg` pair. It also reports load/use and data hazards to the pipeline control logic.

## Interface
Parameters:
- `XLEN`, 64, datapath/register width in bits
- `NREG`, 15, architectural registers; IDs 0..NREG-1 are valid, ID 4'hF = RNONE
- `RID_W`, 4, register-ID width

Ports:
- `clk_i` in 1: single clock, rising edge
- `rst_n_i` in 1: reset, asynchronous, active-low
- `E_stall_i`, `E_bubble_i` in 1 each: E-register control
- `D_stat_i` in 3; `D_pc_i` in XLEN; `D_icode_i`, `D_ifun_i` in 4 each; `D_rA_i`, `D_rB_i` in RID_W each; `D_valC_i`, `D_valP_i` in XLEN each
- `e_dstE_i` in RID_W, `e_valE_i` in XLEN: execute result
- `M_dstM_i` in RID_W, `m_valM_i` in XLEN; `M_dstE_i` in RID_W, `M_valE_i` in XLEN: memory stage
- `W_dstM_i`, `W_dstE_i` in RID_W; `W_valM_i`, `W_valE_i` in XLEN: writeback (also regfile write ports)
- `d_srcA_o`, `d_srcB_o` out RID_W: combinational decode sources
- `load_use_o` out 1: combinational hazard request to stall F/D and bubble E
- `E_stat_o` 3, `E_pc_o` XLEN, `E_icode_o` 4, `E_ifun_o` 4, `E_valC_o`/`E_valA_o`/`E_valB_o` XLEN, `E_dstE_o`/`E_dstM_o`/`E_srcA_o`/`E_srcB_o` RID_W: all outputs, registered

## Operation
- Source/destination selection (RSP = 4, RNONE = F):
  - srcA = rA for RRMOVQ(2), RMMOVQ(4), OPQ(6), PUSHQ(A); RSP for POPQ(B), RET(9); else RNONE.
  - srcB = rB for OPQ, RMMOVQ, MRMOVQ(5); RSP for PUSHQ, POPQ, CALL(8), RET; else RNONE.
  - dstE = rB for RRMOVQ, IRMOVQ(3), OPQ; RSP for PUSHQ, POPQ, CALL, RET; else RNONE.
  - dstM = rA for MRMOVQ, POPQ; else RNONE.
- Register file: NREG × XLEN.
  - Two combinational read ports; reading RNONE or an ID ≥ NREG returns 0.
  - Writes happen at the rising edge from W_dstE/W_valE and W_dstM/W_valM; RNONE is ignored.
  - If W_dstE == W_dstM, W_valM wins (popq %rsp rule).
- valA:
  - valP for CALL or JXX(7).
  - Otherwise forward with fixed priority: e_dstE → M_dstM (m_valM) → M_dstE → W_dstM → W_dstE → regfile.
  - A forwarding source matches only when its ID ≠ RNONE.
- valB: same priority chain, no valP case.
- load_use_o = (E_icode_o ∈ {MRMOVQ, POPQ}) && E_dstM_o ≠ RNONE && E_dstM_o ∈ {d_srcA, d_srcB}.
- E register update on each rising edge:
  - `E_bubble_i` = 1: load bubble (bubble has priority over stall).
  - else `E_stall_i` = 1: hold.
  - else: load the decoded values.
- Bubble value: stat = SAOK(1), icode = NOP(1), ifun = 0, pc/valC/valA/valB = 0, dst/src = RNONE.

## Timing
- Decode outputs (`d_src*_o`, forwarded values, `load_use_o`) are combinational within the D cycle.
- E outputs have 1-cycle latency.
- A regfile write is visible to a direct read in the next cycle; the same-cycle value is covered by W forwarding.
- Reset (asserted asynchronously at any time, including mid-stall):
  - All registers clear to 0 immediately.
  - E outputs take the bubble value (stat 1, icode 1, dst/src F, data 0).
  - Operation resumes at the first rising edge after deassertion.

## Configuration
- `DECODE_FWD_EN` defined:
  - Forwarding network as above.
  - `load_use_o` asserts only for the load/use case.
- `DECODE_FWD_EN` undefined:
  - valA/valB come from the regfile only (valP selection is kept).
  - `load_use_o` asserts whenever a non-RNONE d_srcA/d_srcB equals any of E_dstE_o, E_dstM_o, M_dstE_i, M_dstM_i, W_dstE_i or W_dstM_i.
  - Control uses this signal as a generic data-hazard stall.

## Test plan
- Reset with all inputs X, then release → E_icode_o = 1, E_stat_o = 1, E_dstE_o = F, E_valA_o = 0; reading any register returns 0.
- W writes %rbx = 0x11 and %rcx = 0x22; then D = OPQ rA = 3, rB = 1 → next edge E_valA_o = 0x11, E_valB_o = 0x22, E_dstE_o = 1.
- D = RRMOVQ rA = 2 with e_dstE = 2/0xAA, M_dstE = 2/0xBB, W_dstE = 2/0xCC → E_valA_o = 0xAA. Remove e → 0xBB. Set M_dstM = 2 with m_valM = 0x55 → 0x55.
- E holds MRMOVQ dstM = 3; D = OPQ rA = 3 → load_use_o = 1. Apply E_bubble_i → next E_icode_o = 1. With `DECODE_FWD_EN` undefined and E_dstE = 3, load_use_o = 1 for irmovq-then-addq.
- D = CALL valP = 0x109 → E_valA_o = 0x109, E_srcB_o = 4, E_dstE_o = 4. W_dstE = W_dstM = 4 with valE = 0x10, valM = 0x20 → %rsp = 0x20.
- Assert E_stall_i for 2 cycles while D changes → E outputs hold. Assert rst_n_i low mid-stall → E outputs are the bubble value immediately.
